bus_arbiter: RTL and testbench

Round-robin arbiter sharing the single CPU-style memory bus (request/ready, rw, 32-bit address, 32-bit read/write data) among `NUM_MASTERS` requesters: CPU fetch/data port, DMA, video scan-out. It sits between the masters and the memory/peripheral slave. Each master sees its own private request/ready handshake. At most one transaction is in flight on the slave side at any time.

---
 rtl/bus_pkg.sv | 19 +
 rtl/rr_priority_pick.sv | 41 ++++
 rtl/bus_arbiter.sv | 114 +++++++++++
 tb/tb_bus_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_pkg
// Brief    : Shared bus widths and arbiter state encoding.
// Revision : 1.0
// ============================================================================
package bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_pick
// Brief    : Combinational round-robin winner search starting at a pointer.
// Revision : 1.0
// ============================================================================
module rr_priority_pick
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_request,
    input  logic [IDX_W-1:0]       i_rr_ptr,
    output logic                   o_valid,
    output logic [IDX_W-1:0]       o_winner
);

    localparam logic [IDX_W:0] c_num = (IDX_W+1)'(NUM_MASTERS);

    logic [IDX_W:0] w_sum;

    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        w_sum    = '0;
        // Scan from the farthest offset inward so the request nearest the pointer wins.
        for (int off = NUM_MASTERS - 1; off >= 0; off--) begin
            w_sum = {1'b0, i_rr_ptr} + (IDX_W+1)'(off);
            if (w_sum >= c_num) begin
                w_sum = w_sum - c_num;
            end
            if (i_request[w_sum[IDX_W-1:0]]) begin
                o_valid  = 1'b1;
                o_winner = w_sum[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bus_arbiter
// Brief    : Round-robin arbiter sharing one request/ready memory bus.
// Revision : 1.0
// ============================================================================
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic [NUM_MASTERS-1:0]            i_master_request,
    input  logic [NUM_MASTERS-1:0]            i_master_rw,
    input  logic [NUM_MASTERS*BUS_ADDR_W-1:0] i_master_address,
    input  logic [NUM_MASTERS*BUS_DATA_W-1:0] i_master_wdata,
    output logic [NUM_MASTERS-1:0]            o_master_ready,
    output logic [BUS_DATA_W-1:0]             o_master_rdata,
    output logic                              o_request,
    output logic                              o_rw,
    output logic [BUS_ADDR_W-1:0]             o_address,
    output logic [BUS_DATA_W-1:0]             o_data,
    input  logic                              i_ready,
    input  logic [BUS_DATA_W-1:0]             i_data,
    output logic [IDX_W-1:0]                  o_grant
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_MASTERS - 1);

    arb_state_t            r_state;
    arb_state_t            w_state_next;
    logic [IDX_W-1:0]      r_grant;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic                  w_pick_valid;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_capture;
    logic [BUS_ADDR_W-1:0] w_addr_arr  [NUM_MASTERS];
    logic [BUS_DATA_W-1:0] w_wdata_arr [NUM_MASTERS];

    for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
        assign w_addr_arr[k]  = i_master_address[k*BUS_ADDR_W +: BUS_ADDR_W];
        assign w_wdata_arr[k] = i_master_wdata[k*BUS_DATA_W +: BUS_DATA_W];
    end

    rr_priority_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_pick (
        .i_request (i_master_request),
        .i_rr_ptr  (r_rr_ptr),
        .o_valid   (w_pick_valid),
        .o_winner  (w_pick_idx)
    );

    assign o_master_rdata = i_data;
    assign o_grant        = r_grant;

    always_comb begin
        w_state_next   = r_state;
        w_capture      = 1'b0;
        o_master_ready = '0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // A master that abandoned its request mid-transaction gets no ready.
                o_master_ready[r_grant] = i_ready & i_master_request[r_grant];
                if (i_ready) begin
                    w_state_next = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                if (!i_master_request[r_grant]) begin
                    w_state_next = ARB_IDLE;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ARB_IDLE;
            r_grant   <= '0;
            r_rr_ptr  <= '0;
            o_request <= 1'b0;
            o_rw      <= 1'b0;
            o_address <= '0;
            o_data    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_grant   <= w_pick_idx;
                r_rr_ptr  <= (w_pick_idx == c_last_idx) ? '0 : w_pick_idx + IDX_W'(1);
                o_request <= 1'b1;
                o_rw      <= i_master_rw[w_pick_idx];
                o_address <= w_addr_arr[w_pick_idx];
                o_data    <= w_wdata_arr[w_pick_idx];
            end else if (r_state == ARB_BUSY && i_ready) begin
                o_request <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_arbiter
// Brief    : Randomized self-checking bench for bus_arbiter (2 and 4 masters).
// Revision : 1.0
// ============================================================================
module tb_bus_arbiter;

    localparam int MS_IDLE   = 0;
    localparam int MS_REQ    = 1;
    localparam int MS_SERVED = 2;
    localparam int MS_LINGER = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [3:0]   rw;
    logic [127:0] addr_bus;
    logic [127:0] wdata_bus;
    logic         slv_ready;
    logic [31:0]  slv_data;

    always #5 clk = ~clk;

    logic [1:0]  mrdy2;
    logic [31:0] mrdata2, addr2, data2;
    logic        req2, rw2;
    logic [0:0]  grant2;
    logic [3:0]  mrdy4;
    logic [31:0] mrdata4, addr4, data4;
    logic        req4, rw4;
    logic [1:0]  grant4;

    bus_arbiter #(.NUM_MASTERS(2)) u_dut2 (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_master_request (req[1:0]),
        .i_master_rw      (rw[1:0]),
        .i_master_address (addr_bus[63:0]),
        .i_master_wdata   (wdata_bus[63:0]),
        .o_master_ready   (mrdy2),
        .o_master_rdata   (mrdata2),
        .o_request        (req2),
        .o_rw             (rw2),
        .o_address        (addr2),
        .o_data           (data2),
        .i_ready          (slv_ready),
        .i_data           (slv_data),
        .o_grant          (grant2)
    );

    bus_arbiter #(.NUM_MASTERS(4)) u_dut4 (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_master_request (req),
        .i_master_rw      (rw),
        .i_master_address (addr_bus),
        .i_master_wdata   (wdata_bus),
        .o_master_ready   (mrdy4),
        .o_master_rdata   (mrdata4),
        .o_request        (req4),
        .o_rw             (rw4),
        .o_address        (addr4),
        .o_data           (data4),
        .i_ready          (slv_ready),
        .i_data           (slv_data),
        .o_grant          (grant4)
    );

    // Outputs of whichever instance is under test.
    int          n_act;
    logic [3:0]  s_mrdy;
    logic [31:0] s_rdata, s_addr, s_data;
    logic        s_req, s_rw;
    int          s_grant;

    always_comb begin
        if (n_act == 4) begin
            s_mrdy  = mrdy4;
            s_rdata = mrdata4;
            s_addr  = addr4;
            s_data  = data4;
            s_req   = req4;
            s_rw    = rw4;
            s_grant = int'(grant4);
        end else begin
            s_mrdy  = {2'b00, mrdy2};
            s_rdata = mrdata2;
            s_addr  = addr2;
            s_data  = data2;
            s_req   = req2;
            s_rw    = rw2;
            s_grant = int'(grant2);
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t, masters=%0d)", tag, got, exp, $time, n_act);
        end
    endtask

    // Reference model: who owns the bus, whether its slave access finished, rotation pointer.
    int          mod_owner;
    bit          mod_done;
    int          mod_ptr;
    int          mod_last;
    logic        exp_rw;
    logic [31:0] exp_addr, exp_data;
    logic [3:0]  exp_mrdy;
    logic        prev_sreq;

    int ms_phase [4];
    int ms_cnt   [4];
    int ms_wait  [4];
    int sl_wait;
    int sl_hold;
    bit force_data;
    bit first_chk;

    task automatic new_txn(input int k);
        rw[k]                 = 1'($urandom_range(0, 1));
        addr_bus[k*32 +: 32]  = $urandom;
        wdata_bus[k*32 +: 32] = $urandom;
        req[k]                = 1'b1;
        ms_phase[k]           = MS_REQ;
        ms_wait[k]            = 0;
    endtask

    task automatic model_clear();
        mod_owner = -1;
        mod_done  = 1'b0;
        mod_ptr   = 0;
        mod_last  = 0;
        exp_mrdy  = '0;
        prev_sreq = 1'b0;
        sl_hold   = 0;
        for (int k = 0; k < 4; k++) ms_wait[k] = 0;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req       = '0;
        slv_ready = 1'b0;
        @(posedge clk);
        #1;
        check_value("reset_o_request", s_req, 0);
        check_value("reset_o_rw", s_rw, 0);
        check_value("reset_o_address", s_addr, 0);
        check_value("reset_o_data", s_data, 0);
        check_value("reset_o_grant", s_grant, 0);
        check_value("reset_master_ready", s_mrdy, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_clear();
        // First transaction: master 0 alone reads 0x10 from a one-wait slave.
        for (int k = 0; k < 4; k++) begin
            ms_phase[k] = MS_IDLE;
            ms_cnt[k]   = 6;
        end
        new_txn(0);
        rw[0]               = 1'b0;
        addr_bus[31:0]      = 32'h0000_0010;
        sl_wait             = 1;
        force_data          = 1'b1;
        first_chk           = 1'b1;
    endtask

    task automatic step(input bit sat);
        logic [3:0] rq_e;
        logic       rdy_e;
        logic [3:0] mr_e;
        rq_e  = req;
        rdy_e = slv_ready;
        mr_e  = exp_mrdy;
        @(posedge clk);
        #1;
        // Model advance on the edge just taken.
        if (mod_owner < 0) begin
            for (int off = 0; off < n_act; off++) begin
                int k;
                k = (mod_ptr + off) % n_act;
                if (mod_owner < 0 && rq_e[k]) begin
                    mod_owner   = k;
                    mod_done    = 1'b0;
                    mod_ptr     = (k + 1) % n_act;
                    mod_last    = k;
                    exp_rw      = rw[k];
                    exp_addr    = addr_bus[k*32 +: 32];
                    exp_data    = wdata_bus[k*32 +: 32];
                    ms_phase[k] = MS_SERVED;
                end
            end
        end else if (!mod_done) begin
            if (rdy_e) begin
                mod_done = 1'b1;
                sl_hold  = sat ? 0 : int'($urandom_range(0, 2));
                sl_wait  = sat ? 0 : int'($urandom_range(0, 2));
            end
        end else if (!rq_e[mod_owner]) begin
            mod_owner = -1;
        end
        for (int k = 0; k < n_act; k++) begin
            if (mr_e[k]) begin
                ms_phase[k] = MS_LINGER;
                ms_cnt[k]   = sat ? 0 : int'($urandom_range(0, 2));
            end
        end

        check_value("o_request", s_req, (mod_owner >= 0 && !mod_done));
        check_value("o_grant", s_grant, mod_last);
        if (mod_owner >= 0 && !mod_done) begin
            check_value("o_rw", s_rw, exp_rw);
            check_value("o_address", s_addr, exp_addr);
            check_value("o_data", s_data, exp_data);
        end
        // Fairness measured from the grants the DUT actually issues.
        if (s_req && !prev_sreq) begin
            for (int j = 0; j < n_act; j++) begin
                if (j != s_grant && ms_phase[j] == MS_REQ) ms_wait[j]++;
            end
            if (s_grant < n_act) begin
                check_value("starvation_bound", ms_wait[s_grant] <= n_act - 1, 1);
                ms_wait[s_grant] = 0;
            end
        end
        prev_sreq = s_req;

        for (int k = 0; k < n_act; k++) begin
            if (ms_phase[k] == MS_LINGER) begin
                if (ms_cnt[k] == 0) begin
                    req[k]      = 1'b0;
                    ms_phase[k] = MS_IDLE;
                    ms_cnt[k]   = sat ? 0 : int'($urandom_range(0, 3));
                end else begin
                    ms_cnt[k]--;
                end
            end else if (ms_phase[k] == MS_IDLE) begin
                if (ms_cnt[k] == 0) new_txn(k);
                else ms_cnt[k]--;
            end
        end

        if (mod_owner >= 0 && !mod_done) begin
            if (sl_wait == 0) begin
                slv_ready  = 1'b1;
                slv_data   = force_data ? 32'hDEAD_BEEF : $urandom;
                force_data = 1'b0;
            end else begin
                sl_wait--;
                slv_ready = 1'b0;
            end
        end else if (sl_hold > 0) begin
            sl_hold--;
            slv_ready = 1'b1;
            slv_data  = $urandom;
        end else begin
            slv_ready = 1'b0;
        end

        #1;
        exp_mrdy = '0;
        if (mod_owner >= 0 && !mod_done && slv_ready && req[mod_owner]) exp_mrdy[mod_owner] = 1'b1;
        check_value("master_ready", s_mrdy, exp_mrdy);
        check_value("master_rdata", s_rdata, slv_data);
        if (first_chk && exp_mrdy[0]) begin
            check_value("first_read_data", s_rdata, 32'hDEAD_BEEF);
            first_chk = 1'b0;
        end
    endtask

    task automatic mid_reset(input bit sat);
        int guard;
        guard = 0;
        while (!(mod_owner >= 0 && !mod_done) && guard < 50) begin
            step(sat);
            guard++;
        end
        check_value("busy_reached_in_bound", guard < 50, 1);
        #2;
        rst = 1'b1;
        #1;
        check_value("async_reset_o_request", s_req, 0);
        check_value("async_reset_master_ready", s_mrdy, 0);
        check_value("async_reset_o_grant", s_grant, 0);
        slv_ready = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_clear();
        sl_wait = sat ? 0 : int'($urandom_range(0, 2));
        for (int k = 0; k < n_act; k++) begin
            if (ms_phase[k] == MS_SERVED) begin
                ms_phase[k] = MS_REQ;
            end else if (ms_phase[k] == MS_LINGER) begin
                req[k]      = 1'b0;
                ms_phase[k] = MS_IDLE;
                ms_cnt[k]   = 1;
            end
        end
        if (ms_phase[0] == MS_IDLE) new_txn(0);
    endtask

    task automatic run_phase(input int n, input int cycles, input bit sat);
        n_act = n;
        #1;
        apply_reset();
        for (int c = 0; c < cycles; c++) begin
            if (c == cycles / 2) mid_reset(sat);
            step(sat);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        rw        = '0;
        addr_bus  = '0;
        wdata_bus = '0;
        slv_ready = 1'b0;
        slv_data  = '0;
        n_act     = 2;
        model_clear();
        run_phase(2, 300, 1'b0);
        run_phase(2, 60, 1'b1);
        run_phase(4, 400, 1'b0);
        run_phase(4, 80, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
